// File: rtl/ram_bytewide_ws_if.sv
// CPU memory-port bundle for ram_bytewide_ws: MOV/MOC handshake, size/sign control,
// address, write data, read data and fault flag.
interface ram_bytewide_ws_if;
  logic        MOV;
  logic        ReadWrite;
  logic [2:0]  MS;
  logic [31:0] DataIn;
  logic [31:0] Address;
  logic        MOC;
  logic [31:0] DataOut;
  logic        MFA;

  modport master (
    output MOV, ReadWrite, MS, DataIn, Address,
    input  MOC, DataOut, MFA
  );

  modport slave (
    input  MOV, ReadWrite, MS, DataIn, Address,
    output MOC, DataOut, MFA
  );
endinterface

// File: rtl/ram_bytewide_ws.sv
// Byte-addressed big-endian data RAM with byte/halfword/word access, optional sign
// extension, programmable wait states and an optional misalignment fault.
module ram_bytewide_ws #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  ram_bytewide_ws_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // CAPTURE is the cycle after the request is latched; it sets the capture-to-MOC
  // latency at 2+WAIT_STATES edges and the 4-cycle back-to-back period.
  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    WAIT,
    ACCESS,
    DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [3:0]     r_cnt;
  logic           r_rw;
  logic [2:0]     r_ms;
  logic [31:0]    r_din;
  logic [AW-1:0]  r_addr;
  logic [31:0]    r_dout;
  logic [7:0]     r_mem [DEPTH];

  logic [AW-1:0]  w_idx   [4];
  logic [7:0]     w_rbyte [4];
  logic [31:0]    w_rdata;
  logic [1:0]     w_size;
  logic           w_fault;
  logic           w_unusedAddr;

  assign w_unusedAddr = &{1'b0, bus.Address[31:AW]};
  assign w_size = r_ms[1:0];

  assign w_fault = (w_size == 2'b11) ||
                   ((ALIGN_CHECK != 0) &&
                    (((w_size == 2'b01) && r_addr[0]) ||
                     ((w_size == 2'b10) && (r_addr[1:0] != 2'b00))));

  // Byte lanes in big-endian order; the index wraps naturally at DEPTH.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_idx[k]   = r_addr + AW'(k);
      w_rbyte[k] = r_mem[w_idx[k]];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_size)
      2'b00:   w_rdata = {{24{r_ms[2] & w_rbyte[0][7]}}, w_rbyte[0]};
      2'b01:   w_rdata = {{16{r_ms[2] & w_rbyte[0][7]}}, w_rbyte[0], w_rbyte[1]};
      2'b10:   w_rdata = {w_rbyte[0], w_rbyte[1], w_rbyte[2], w_rbyte[3]};
      default: w_rdata = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.MOV) w_next = CAPTURE;
      CAPTURE: w_next = (WAIT_STATES > 0) ? WAIT : ACCESS;
      WAIT:    if (r_cnt == 4'd0) w_next = ACCESS;
      ACCESS:  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rw    <= 1'b0;
      r_ms    <= '0;
      r_din   <= '0;
      r_addr  <= '0;
      r_dout  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.MOV) begin
        r_rw   <= bus.ReadWrite;
        r_ms   <= bus.MS;
        r_din  <= bus.DataIn;
        r_addr <= bus.Address[AW-1:0];
      end
      if (r_state == CAPTURE) begin
        r_cnt <= CNT_LOAD;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == ACCESS && r_rw && !w_fault) begin
        r_dout <= w_rdata;
      end
    end
  end

  // Storage is deliberately not reset; a reset before ACCESS drops the pending write.
  always_ff @(posedge CLK) begin
    if (r_state == ACCESS && !r_rw && !w_fault) begin
      case (w_size)
        2'b00: r_mem[w_idx[0]] <= r_din[7:0];
        2'b01: begin
          r_mem[w_idx[0]] <= r_din[15:8];
          r_mem[w_idx[1]] <= r_din[7:0];
        end
        2'b10: begin
          r_mem[w_idx[0]] <= r_din[31:24];
          r_mem[w_idx[1]] <= r_din[23:16];
          r_mem[w_idx[2]] <= r_din[15:8];
          r_mem[w_idx[3]] <= r_din[7:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.MOC     = (r_state == DONE);
  assign bus.MFA     = (r_state == DONE) && w_fault;
  assign bus.DataOut = r_dout;

endmodule

// File: tb/tb_ram_bytewide_ws.sv
// Bench for ram_bytewide_ws: three instances (WS=1/AC=1, WS=0/AC=0, WS=3/AC=1) driven
// by a vector table, randomized traffic against a byte-array model, and timing sequences.
module tb_ram_bytewide_ws;

  typedef struct {
    logic        rw;
    logic [2:0]  ms;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] expData;
    logic        expMfa;
  } vec_t;

  int wsTab[3] = '{1, 0, 3};
  int acTab[3] = '{1, 0, 1};

  logic        clk;
  logic        tbRst  [3];
  logic        tbMov  [3];
  logic        tbRw   [3];
  logic [2:0]  tbMs   [3];
  logic [31:0] tbDin  [3];
  logic [31:0] tbAddr [3];
  logic        tbMoc  [3];
  logic        tbMfa  [3];
  logic [31:0] tbDout [3];

  logic [7:0]  modelMem  [3][256];
  logic [31:0] modelDout [3];

  int checkCount = 0;
  int passCount  = 0;

  ram_bytewide_ws_if busA ();
  ram_bytewide_ws_if busB ();
  ram_bytewide_ws_if busC ();

  assign busA.MOV = tbMov[0];  assign busA.ReadWrite = tbRw[0];  assign busA.MS = tbMs[0];
  assign busA.DataIn = tbDin[0];  assign busA.Address = tbAddr[0];
  assign busB.MOV = tbMov[1];  assign busB.ReadWrite = tbRw[1];  assign busB.MS = tbMs[1];
  assign busB.DataIn = tbDin[1];  assign busB.Address = tbAddr[1];
  assign busC.MOV = tbMov[2];  assign busC.ReadWrite = tbRw[2];  assign busC.MS = tbMs[2];
  assign busC.DataIn = tbDin[2];  assign busC.Address = tbAddr[2];

  assign tbMoc[0] = busA.MOC;  assign tbMfa[0] = busA.MFA;  assign tbDout[0] = busA.DataOut;
  assign tbMoc[1] = busB.MOC;  assign tbMfa[1] = busB.MFA;  assign tbDout[1] = busB.DataOut;
  assign tbMoc[2] = busC.MOC;  assign tbMfa[2] = busC.MFA;  assign tbDout[2] = busC.DataOut;

  ram_bytewide_ws #(.DEPTH(256), .WAIT_STATES(1), .ALIGN_CHECK(1)) dutA (
    .CLK(clk), .RESET(tbRst[0]), .bus(busA.slave)
  );
  ram_bytewide_ws #(.DEPTH(256), .WAIT_STATES(0), .ALIGN_CHECK(0)) dutB (
    .CLK(clk), .RESET(tbRst[1]), .bus(busB.slave)
  );
  ram_bytewide_ws #(.DEPTH(256), .WAIT_STATES(3), .ALIGN_CHECK(1)) dutC (
    .CLK(clk), .RESET(tbRst[2]), .bus(busC.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference behaviour: size in bytes, big-endian byte order, wrap modulo 256.
  task automatic modelAccess(input int idx, input logic rw, input logic [2:0] ms,
                             input logic [31:0] addr, input logic [31:0] din,
                             output logic [31:0] expD, output logic expF);
    int n;
    int a;
    longint v;
    n = (ms[1:0] == 2'b00) ? 1 : (ms[1:0] == 2'b01) ? 2 : 4;
    a = int'(addr % 256);
    expF = (ms[1:0] == 2'b11) || (acTab[idx] == 1 && (a % n) != 0);
    if (!expF) begin
      if (!rw) begin
        for (int k = 0; k < n; k++)
          modelMem[idx][(a + k) % 256] = 8'((din >> (8 * (n - 1 - k))) & 32'hFF);
      end else begin
        v = 0;
        for (int k = 0; k < n; k++) v = v * 256 + longint'(modelMem[idx][(a + k) % 256]);
        if (ms[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
          v = v + (longint'(1) << 32) - (longint'(1) << (8 * n));
        modelDout[idx] = 32'(v);
      end
    end
    expD = modelDout[idx];
  endtask

  task automatic applyStimulus(input int idx, input logic rw, input logic [2:0] ms,
                               input logic [31:0] addr, input logic [31:0] din,
                               output logic [31:0] dout, output logic mfa,
                               output int lat, output logic mocAfter);
    @(negedge clk);
    tbRw[idx] = rw;  tbMs[idx] = ms;  tbAddr[idx] = addr;  tbDin[idx] = din;
    tbMov[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tbMov[idx] = 1'b0;
    lat = -1;  dout = '0;  mfa = 1'b0;  mocAfter = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (tbMoc[idx]) begin
        lat = j;  dout = tbDout[idx];  mfa = tbMfa[idx];
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (lat >= 0) begin
      @(posedge clk);
      @(negedge clk);
      mocAfter = tbMoc[idx];
    end
  endtask

  task automatic runCheck(input int idx, input logic rw, input logic [2:0] ms,
                          input logic [31:0] addr, input logic [31:0] din,
                          input logic [31:0] expD, input logic expF, input string name);
    logic [31:0] dout;
    logic mfa, mocAfter;
    int lat;
    applyStimulus(idx, rw, ms, addr, din, dout, mfa, lat, mocAfter);
    checkOutput({name, ".data"}, dout, expD);
    checkOutput({name, ".mfa"}, 32'(mfa), 32'(expF));
    checkOutput({name, ".latency"}, 32'(lat), 32'(2 + wsTab[idx]));
    checkOutput({name, ".mocWidth"}, 32'(mocAfter), 32'd0);
  endtask

  vec_t vecTab[$];

  initial begin
    logic [31:0] expD, addr, din;
    logic expF, rw;
    logic [2:0] ms;
    logic [19:0] hist, histExp;
    logic [11:0] win, winExp;
    int mocSeen;

    vecTab.push_back('{1'b0, 3'b000, 32'd0,  32'h00000081, 32'h00000000, 1'b0});
    vecTab.push_back('{1'b0, 3'b000, 32'd1,  32'hABCDEF02, 32'h00000000, 1'b0});
    vecTab.push_back('{1'b0, 3'b000, 32'd2,  32'h00000003, 32'h00000000, 1'b0});
    vecTab.push_back('{1'b0, 3'b000, 32'd3,  32'h00000004, 32'h00000000, 1'b0});
    vecTab.push_back('{1'b1, 3'b000, 32'd0,  32'h0,        32'h00000081, 1'b0});
    vecTab.push_back('{1'b1, 3'b100, 32'd0,  32'h0,        32'hFFFFFF81, 1'b0});
    vecTab.push_back('{1'b1, 3'b101, 32'd0,  32'h0,        32'hFFFF8102, 1'b0});
    vecTab.push_back('{1'b1, 3'b010, 32'd0,  32'h0,        32'h81020304, 1'b0});
    vecTab.push_back('{1'b1, 3'b110, 32'd0,  32'h0,        32'h81020304, 1'b0});
    vecTab.push_back('{1'b1, 3'b001, 32'd2,  32'h0,        32'h00000304, 1'b0});
    vecTab.push_back('{1'b0, 3'b010, 32'd28, 32'hC0000001, 32'h00000304, 1'b0});
    vecTab.push_back('{1'b1, 3'b000, 32'd28, 32'h0,        32'h000000C0, 1'b0});
    vecTab.push_back('{1'b1, 3'b000, 32'd29, 32'h0,        32'h00000000, 1'b0});
    vecTab.push_back('{1'b1, 3'b000, 32'd30, 32'h0,        32'h00000000, 1'b0});
    vecTab.push_back('{1'b1, 3'b000, 32'd31, 32'h0,        32'h00000001, 1'b0});
    vecTab.push_back('{1'b0, 3'b001, 32'd30, 32'h00008181, 32'h00000001, 1'b0});
    vecTab.push_back('{1'b1, 3'b010, 32'd28, 32'h0,        32'hC0008181, 1'b0});
    vecTab.push_back('{1'b0, 3'b001, 32'd26, 32'h00001234, 32'hC0008181, 1'b0});
    vecTab.push_back('{1'b0, 3'b010, 32'd26, 32'hDEADBEEF, 32'hC0008181, 1'b1});
    vecTab.push_back('{1'b1, 3'b001, 32'd26, 32'h0,        32'h00001234, 1'b0});
    vecTab.push_back('{1'b1, 3'b010, 32'd28, 32'h0,        32'hC0008181, 1'b0});
    vecTab.push_back('{1'b1, 3'b011, 32'd0,  32'h0,        32'hC0008181, 1'b1});
    vecTab.push_back('{1'b1, 3'b001, 32'd1,  32'h0,        32'hC0008181, 1'b1});
    vecTab.push_back('{1'b1, 3'b101, 32'd30, 32'h0,        32'hFFFF8181, 1'b0});
    vecTab.push_back('{1'b0, 3'b011, 32'd0,  32'h000000FF, 32'hFFFF8181, 1'b1});
    vecTab.push_back('{1'b1, 3'b000, 32'd0,  32'h0,        32'h00000081, 1'b0});
    vecTab.push_back('{1'b1, 3'b010, 32'h12345600, 32'h0,  32'h81020304, 1'b0});

    for (int i = 0; i < 3; i++) begin
      tbRst[i] = 1'b1;  tbMov[i] = 1'b0;  tbRw[i] = 1'b0;
      tbMs[i] = '0;  tbDin[i] = '0;  tbAddr[i] = '0;  modelDout[i] = '0;
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset%0d.moc", i), 32'(tbMoc[i]), 32'd0);
      checkOutput($sformatf("reset%0d.mfa", i), 32'(tbMfa[i]), 32'd0);
      checkOutput($sformatf("reset%0d.dout", i), tbDout[i], 32'd0);
    end
    for (int i = 0; i < 3; i++) tbRst[i] = 1'b0;

    for (int i = 0; i < vecTab.size(); i++)
      runCheck(0, vecTab[i].rw, vecTab[i].ms, vecTab[i].addr, vecTab[i].din,
               vecTab[i].expData, vecTab[i].expMfa, $sformatf("vec%0d", i));
    modelDout[0] = vecTab[vecTab.size() - 1].expData;

    // Fill the whole array so every random read hits defined storage.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 64; w++) begin
        din = $urandom;
        modelAccess(d, 1'b0, 3'b010, 32'(4 * w), din, expD, expF);
        runCheck(d, 1'b0, 3'b010, 32'(4 * w), din, expD, expF, $sformatf("fill%0d_%0d", d, w));
      end
    end

    for (int t = 0; t < 120; t++) begin
      rw = 1'($urandom_range(0, 1));
      ms = 3'($urandom_range(0, 7));
      addr = {24'($urandom), 8'($urandom_range(0, 255))};
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      din = $urandom;
      modelAccess(t % 2, rw, ms, addr, din, expD, expF);
      runCheck(t % 2, rw, ms, addr, din, expD, expF, $sformatf("rand%0d", t));
    end

    // Unaligned word write wraps past the top of the array when alignment is not checked.
    runCheck(1, 1'b0, 3'b010, 32'd255, 32'h11223344, modelDout[1], 1'b0, "wrapWrite");
    runCheck(1, 1'b1, 3'b000, 32'd255, 32'h0, 32'h00000011, 1'b0, "wrap255");
    runCheck(1, 1'b1, 3'b000, 32'd0,   32'h0, 32'h00000022, 1'b0, "wrap0");
    runCheck(1, 1'b1, 3'b000, 32'd1,   32'h0, 32'h00000033, 1'b0, "wrap1");
    runCheck(1, 1'b1, 3'b000, 32'd2,   32'h0, 32'h00000044, 1'b0, "wrap2");
    runCheck(1, 1'b1, 3'b010, 32'd255, 32'h0, 32'h11223344, 1'b0, "wrapWord");
    runCheck(1, 1'b1, 3'b001, 32'd1,   32'h0, 32'h00003344, 1'b0, "unalignedHalf");

    // MOV held high with zero wait states: one MOC pulse every 4 cycles.
    @(negedge clk);
    tbRw[1] = 1'b1;  tbMs[1] = 3'b000;  tbAddr[1] = 32'd0;  tbMov[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      hist[i] = tbMoc[1];
      histExp[i] = ((i % 4) == 2);
    end
    tbMov[1] = 1'b0;
    checkOutput("heldMovPattern", 32'(hist), 32'(histExp));
    checkOutput("heldMovData", tbDout[1], 32'h00000022);

    // Reset during WAIT discards the pending write and clears the outputs.
    runCheck(2, 1'b0, 3'b000, 32'd3, 32'h0000005A, 32'h0, 1'b0, "cPreWrite");
    runCheck(2, 1'b1, 3'b000, 32'd3, 32'h0, 32'h0000005A, 1'b0, "cPreRead");
    @(negedge clk);
    tbRw[2] = 1'b0;  tbMs[2] = 3'b000;  tbAddr[2] = 32'd3;  tbDin[2] = 32'h000000AA;
    tbMov[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tbMov[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    tbRst[2] = 1'b1;
    #1;
    checkOutput("midReset.moc", 32'(tbMoc[2]), 32'd0);
    checkOutput("midReset.mfa", 32'(tbMfa[2]), 32'd0);
    checkOutput("midReset.dout", tbDout[2], 32'd0);
    mocSeen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) tbRst[2] = 1'b0;
      if (tbMoc[2]) mocSeen++;
    end
    checkOutput("midReset.noMoc", 32'(mocSeen), 32'd0);
    runCheck(2, 1'b1, 3'b000, 32'd3, 32'h0, 32'h0000005A, 1'b0, "postResetRead");

    // MOV pulses while the request is in flight must not start another one.
    @(negedge clk);
    tbRw[2] = 1'b1;  tbMs[2] = 3'b100;  tbAddr[2] = 32'd3;  tbMov[2] = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      tbMov[2] = (j == 1 || j == 2);
      win[j] = tbMoc[2];
      winExp[j] = (j == 5);
      @(posedge clk);
    end
    @(negedge clk);
    tbMov[2] = 1'b0;
    checkOutput("movDuringWait", 32'(win), 32'(winExp));
    checkOutput("movDuringWait.data", tbDout[2], 32'h0000005A);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
